ins_main_memory: RTL and testbench



---
 rtl/ins_main_memory.sv | 134 +++++++++++++
 tb/tb_ins_main_memory.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ins_main_memory.sv
// Block-granular instruction memory answering cache refills after a fixed latency.
// Optional macro IMEM_RANGE_CHECK_EN adds addr_error and zeroes out-of-range lines.
`timescale 1ns/1ps
module ins_main_memory #(
  parameter int DEPTH_BLOCKS = 256,
  parameter int LATENCY      = 4,
  localparam int IDX_W       = $clog2(DEPTH_BLOCKS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               read,
  input  logic [27:0]        address,
  output logic [127:0]       readdata,
  output logic               busywait,
`ifdef IMEM_RANGE_CHECK_EN
  output logic               addr_error,
`endif
  input  logic               prog_we,
  input  logic [IDX_W+1:0]   prog_addr,
  input  logic [31:0]        prog_wdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
      $error("ins_main_memory: LATENCY must be in 1..255");
    end
    if (DEPTH_BLOCKS < 2 || (DEPTH_BLOCKS & (DEPTH_BLOCKS - 1)) != 0) begin : g_bad_depth
      $error("ins_main_memory: DEPTH_BLOCKS must be a power of two >= 2");
    end
  endgenerate

  logic [1:0]       state_r;
  logic [7:0]       count_r;
  logic [IDX_W-1:0] idx_r;
  logic [31:0]      mem_r [0:4*DEPTH_BLOCKS-1];
  logic [127:0]     line_s;
  logic             done_s;

  assign done_s = (state_r == BUSY) && (count_r == 8'd0);

`ifdef IMEM_RANGE_CHECK_EN
  logic flag_r;
  logic out_of_range_s;

  assign out_of_range_s = |address[27:IDX_W];

  // Flag latched at acceptance; addr_error shown only for the ACK cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_r     <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      if (state_r == IDLE && read) begin
        flag_r <= out_of_range_s;
      end
      addr_error <= done_s ? flag_r : 1'b0;
    end
  end

  // Line assembly; flagged requests return zeros.
  always_comb begin
    line_s = 128'd0;
    if (!flag_r) begin
      line_s = {mem_r[{idx_r, 2'd3}], mem_r[{idx_r, 2'd2}],
                mem_r[{idx_r, 2'd1}], mem_r[{idx_r, 2'd0}]};
    end else begin
      line_s = 128'd0;
    end
  end
`else
  logic unused_addr_s;
  assign unused_addr_s = ^address[27:IDX_W];

  // Line assembly; upper address bits alias onto the low index.
  always_comb begin
    line_s = {mem_r[{idx_r, 2'd3}], mem_r[{idx_r, 2'd2}],
              mem_r[{idx_r, 2'd1}], mem_r[{idx_r, 2'd0}]};
  end
`endif

  // Request FSM: accept in IDLE, count down in BUSY, present the line in ACK.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      count_r  <= 8'd0;
      idx_r    <= {IDX_W{1'b0}};
      readdata <= 128'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (read) begin
            idx_r   <= address[IDX_W-1:0];
            count_r <= LAT_M1;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          if (count_r != 8'd0) begin
            count_r <= count_r - 8'd1;
          end else begin
            readdata <= line_s;
            state_r  <= ACK;
          end
        end
        ACK:     state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Program-load port; writes outside IDLE are dropped so a served line cannot change.
  always_ff @(posedge clock) begin
    if (prog_we && state_r == IDLE) begin
      mem_r[prog_addr] <= prog_wdata;
    end
  end

  // busywait follows read in IDLE so the cache never sees a false low.
  always_comb begin
    busywait = 1'b0;
    case (state_r)
      IDLE:    busywait = read & ~reset;
      BUSY:    busywait = 1'b1;
      ACK:     busywait = 1'b0;
      default: busywait = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ins_main_memory.sv
// Directed bench for ins_main_memory: a LATENCY=4 instance and a LATENCY=1 instance.
`timescale 1ns/1ps
module tb_ins_main_memory;

  localparam logic [127:0] LINE0 = 128'h00300193_00200113_00100093_00000013;
  localparam logic [127:0] LINE1 = 128'hA1000003_A1000002_A1000001_A1000000;
  localparam logic [127:0] LINE2 = 128'hA2000003_A2000002_A2000001_A2000000;
  localparam logic [127:0] LINE5 = 128'h0;
  localparam logic [127:0] LINE7 = 128'hB7000003_B7000002_B7000001_B7000000;

  logic         clock = 1'b0;
  logic         reset;
  logic         read, read1;
  logic [27:0]  address, address1;
  logic [127:0] readdata, readdata1;
  logic         busywait, busywait1;
  logic         prog_we;
  logic [9:0]   prog_addr;
  logic [31:0]  prog_wdata;
`ifdef IMEM_RANGE_CHECK_EN
  logic         addr_error, addr_error1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ins_main_memory #(.DEPTH_BLOCKS(256), .LATENCY(4)) dut (
    .clock(clock), .reset(reset), .read(read), .address(address),
    .readdata(readdata), .busywait(busywait),
`ifdef IMEM_RANGE_CHECK_EN
    .addr_error(addr_error),
`endif
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
  );

  ins_main_memory #(.DEPTH_BLOCKS(256), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .read(read1), .address(address1),
    .readdata(readdata1), .busywait(busywait1),
`ifdef IMEM_RANGE_CHECK_EN
    .addr_error(addr_error1),
`endif
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
  );

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_line(input int line, input logic [127:0] v);
    for (int k = 0; k < 4; k++) begin
      prog_we    = 1'b1;
      prog_addr  = 10'(4 * line + k);
      prog_wdata = v[32*k +: 32];
      tick();
    end
    prog_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; read1 = 1'b0; address = 28'd0; address1 = 28'd0;
    prog_we = 1'b0; prog_addr = 10'd0; prog_wdata = 32'd0;
    tick();
    tick();
    chk("rst_busy", busywait, 128'd0);
    chk("rst_data", readdata, 128'd0);
    chk("rst_data1", readdata1, 128'd0);
`ifdef IMEM_RANGE_CHECK_EN
    chk("rst_addr_error", addr_error, 128'd0);
`endif
    reset = 1'b0;
    tick();
    load_line(0, LINE0);
    load_line(1, LINE1);
    load_line(2, LINE2);
    load_line(5, LINE5);
    load_line(7, LINE7);

    // Basic line-0 read with LATENCY=4.
    read = 1'b1; address = 28'h0;
    #1 chk("t1_comb_busy", busywait, 128'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_busy", busywait, 128'd1);
    end
    chk("t1_data_pending", readdata, 128'd0);
    tick();
    chk("t1_ack_busy", busywait, 128'd0);
    chk("t1_line0", readdata, LINE0);
`ifdef IMEM_RANGE_CHECK_EN
    chk("t1_no_addr_error", addr_error, 128'd0);
`endif
    read = 1'b0;
    tick();
    chk("t1_idle_busy", busywait, 128'd0);
    chk("t1_hold", readdata, LINE0);

    // Read held through ACK: one transaction, next acceptance at N+6.
    read = 1'b1; address = 28'h0000005;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_busy", busywait, 128'd1);
    end
    tick();
    chk("t2_ack_busy", busywait, 128'd0);
    chk("t2_line5", readdata, LINE5);
    tick();
    chk("t2_idle_busy_comb", busywait, 128'd1);
    chk("t2_hold", readdata, LINE5);
    address = 28'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_second_busy", busywait, 128'd1);
    end
    tick();
    chk("t2_second_ack", busywait, 128'd0);
    chk("t2_second_line0", readdata, LINE0);
    read = 1'b0;
    tick();

    // Address change, read drop and program write during BUSY are all ignored.
    read = 1'b1; address = 28'h0;
    tick();
    address = 28'h7; read = 1'b0;
    prog_we = 1'b1; prog_addr = 10'd0; prog_wdata = 32'hDEADBEEF;
    #1 chk("t3_busy_no_abort", busywait, 128'd1);
    tick();
    prog_we = 1'b0;
    tick();
    tick();
    chk("t3_still_busy", busywait, 128'd1);
    tick();
    chk("t3_ack_busy", busywait, 128'd0);
    chk("t3_latched_line0", readdata, LINE0);
    tick();
    read = 1'b1; address = 28'h0;
    for (int i = 0; i < 5; i++) tick();
    chk("t3_write_dropped", readdata, LINE0);
    read = 1'b0;
    tick();

    // Reset two edges into BUSY, then a fresh read completes normally.
    read = 1'b1; address = 28'h1;
    tick();
    tick();
    reset = 1'b1;
    #1 chk("t4_rst_busy", busywait, 128'd0);
    chk("t4_rst_data", readdata, 128'd0);
    tick();
    chk("t4_rst_hold_busy", busywait, 128'd0);
    reset = 1'b0;
    #1 chk("t4_comb_busy", busywait, 128'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_busy", busywait, 128'd1);
    end
    tick();
    chk("t4_ack_busy", busywait, 128'd0);
    chk("t4_line1", readdata, LINE1);
    read = 1'b0;
    tick();

    // LATENCY=1 back-to-back cache-style requests to lines 1 and 2.
    read1 = 1'b1; address1 = 28'h1;
    #1 chk("t5_comb_busy", busywait1, 128'd1);
    tick();
    chk("t5_busy_a", busywait1, 128'd1);
    tick();
    chk("t5_ack_a", busywait1, 128'd0);
    chk("t5_line1", readdata1, LINE1);
    address1 = 28'h2;
    tick();
    chk("t5_idle_busy", busywait1, 128'd1);
    chk("t5_hold_line1", readdata1, LINE1);
    tick();
    chk("t5_busy_b", busywait1, 128'd1);
    tick();
    chk("t5_ack_b", busywait1, 128'd0);
    chk("t5_line2", readdata1, LINE2);
    read1 = 1'b0;
    tick();
    chk("t5_idle_end", busywait1, 128'd0);
    chk("t5_hold_line2", readdata1, LINE2);

    // Out-of-range block address.
    read = 1'b1; address = 28'h0000100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_busy", busywait, 128'd1);
    end
    tick();
    chk("t6_ack_busy", busywait, 128'd0);
`ifdef IMEM_RANGE_CHECK_EN
    chk("t6_zero_line", readdata, 128'd0);
    chk("t6_addr_error", addr_error, 128'd1);
`else
    chk("t6_alias_line0", readdata, LINE0);
`endif
    read = 1'b0;
    tick();
`ifdef IMEM_RANGE_CHECK_EN
    chk("t6_addr_error_clear", addr_error, 128'd0);
    chk("t6_hold_zero", readdata, 128'd0);
`else
    chk("t6_hold_line0", readdata, LINE0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
